// File: rtl/vector_reader.sv
// vector_reader: loads up to MAX_NODES entries from block RAM over a four-phase read handshake.
// Optional macro VECTOR_READER_CHECKSUM_EN adds an XOR checksum output of the loaded entries.

`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 16
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 32
`endif
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module vector_reader #(
  parameter int unsigned MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int unsigned INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int unsigned VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
  parameter int unsigned MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int unsigned MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) (
  input  logic                   reset,
  input  logic                   clock,
  input  logic                   enable,
  input  logic [MADDR_WIDTH-1:0] starting_address,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  output logic [INDEX_WIDTH-1:0] vector [MAX_NODES],
  output logic                   mem_read_enable,
  input  logic                   mem_read_ready,
  output wire  [MADDR_WIDTH-1:0] mem_addr,
  input  logic [MDATA_WIDTH-1:0] mem_read_data,
`ifdef VECTOR_READER_CHECKSUM_EN
  output logic [INDEX_WIDTH-1:0] checksum,
`endif
  output logic                   ready
);

  typedef enum logic [1:0] {StIdle, StRequest, StRelease, StDone} state_e;

  // Count register must hold MAX_NODES itself; the entry index only needs MAX_NODES-1.
  localparam int unsigned CntW = $clog2(MAX_NODES + 1);
  localparam int unsigned IdxW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam logic [INDEX_WIDTH-1:0] MaxNodesIdx = INDEX_WIDTH'(MAX_NODES);
  localparam logic [MADDR_WIDTH-1:0] AddrStep = MADDR_WIDTH'(MADDR_WIDTH / 8);

  state_e                 state_q;
  logic [CntW-1:0]        count_q;
  logic [CntW-1:0]        index_q;
  logic [MADDR_WIDTH-1:0] addr_q;

  // Upper data bits and VALUE_WIDTH are intentionally not consumed.
  logic unused_ok;
  assign unused_ok = ^{mem_read_data, VALUE_WIDTH};

  // Bus is shared: only drive it while a read request is outstanding.
  assign mem_addr = mem_read_enable ? addr_q : 'z;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      mem_read_enable <= 1'b0;
      ready           <= 1'b0;
      index_q         <= '0;
      count_q         <= '0;
      addr_q          <= '0;
      for (int i = 0; i < MAX_NODES; i++) vector[i] <= '0;
`ifdef VECTOR_READER_CHECKSUM_EN
      checksum        <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            addr_q  <= starting_address;
            index_q <= '0;
            count_q <= (number_of_nodes > MaxNodesIdx) ? CntW'(MAX_NODES)
                                                       : number_of_nodes[CntW-1:0];
`ifdef VECTOR_READER_CHECKSUM_EN
            checksum <= '0;
`endif
            if (number_of_nodes != '0) begin
              state_q         <= StRequest;
              mem_read_enable <= 1'b1;
            end else begin
              state_q <= StDone;
              ready   <= 1'b1;
            end
          end
        end
        StRequest: begin
          if (mem_read_ready) begin
            vector[index_q[IdxW-1:0]] <= mem_read_data[INDEX_WIDTH-1:0];
`ifdef VECTOR_READER_CHECKSUM_EN
            checksum <= checksum ^ mem_read_data[INDEX_WIDTH-1:0];
`endif
            mem_read_enable <= 1'b0;
            state_q         <= StRelease;
          end
        end
        StRelease: begin
          // Wait for the memory to drop its valid before the next request.
          if (!mem_read_ready) begin
            index_q <= index_q + CntW'(1);
            if (index_q + CntW'(1) == count_q) begin
              state_q <= StDone;
              ready   <= 1'b1;
            end else begin
              state_q         <= StRequest;
              mem_read_enable <= 1'b1;
              addr_q          <= addr_q + AddrStep;
            end
          end
        end
        StDone: begin
          if (!enable) begin
            ready   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_reader.sv
// Table-driven bench for vector_reader with a handshaking block RAM model.
module tb_vector_reader;
  localparam int unsigned MaxNodes   = 8;
  localparam int unsigned IndexWidth = 16;
  localparam int unsigned ValueWidth = 32;
  localparam int unsigned MaddrWidth = 32;
  localparam int unsigned MdataWidth = 32;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  enable = 1'b0;
  logic [MaddrWidth-1:0] starting_address = '0;
  logic [IndexWidth-1:0] number_of_nodes = '0;
  logic [IndexWidth-1:0] vector [MaxNodes];
  logic                  mem_read_enable;
  logic                  mem_read_ready;
  wire  [MaddrWidth-1:0] mem_addr;
  logic [MdataWidth-1:0] mem_read_data;
  logic                  ready;
`ifdef VECTOR_READER_CHECKSUM_EN
  logic [IndexWidth-1:0] checksum;
`endif

  vector_reader #(
    .MAX_NODES  (MaxNodes),
    .INDEX_WIDTH(IndexWidth),
    .VALUE_WIDTH(ValueWidth),
    .MADDR_WIDTH(MaddrWidth),
    .MDATA_WIDTH(MdataWidth)
  ) dut (
    .reset           (reset),
    .clock           (clock),
    .enable          (enable),
    .starting_address(starting_address),
    .number_of_nodes (number_of_nodes),
    .vector          (vector),
    .mem_read_enable (mem_read_enable),
    .mem_read_ready  (mem_read_ready),
    .mem_addr        (mem_addr),
    .mem_read_data   (mem_read_data),
`ifdef VECTOR_READER_CHECKSUM_EN
    .checksum        (checksum),
`endif
    .ready           (ready)
  );

  always #5 clock = ~clock;

  // Memory model: 64 words, word index = addr[7:2], rd_delay wait cycles per read.
  logic [31:0] mem [64];
  int          rd_delay = 0;
  int          wait_cnt = 0;
  logic        en_prev = 1'b0;
  int          txn_cnt = 0;
  int          overlap_cnt = 0;
  logic [31:0] txn_addr [64];

  always @(posedge clock) begin
    if (reset) begin
      mem_read_ready <= 1'b0;
      mem_read_data  <= '0;
      wait_cnt       <= 0;
    end else if (mem_read_enable && !mem_read_ready) begin
      if (wait_cnt >= rd_delay) begin
        mem_read_ready <= 1'b1;
        mem_read_data  <= mem[mem_addr[7:2]];
        wait_cnt       <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else if (!mem_read_enable) begin
      mem_read_ready <= 1'b0;
    end
  end

  always @(posedge clock) begin
    en_prev <= mem_read_enable;
    if (mem_read_enable && !en_prev) begin
      txn_addr[txn_cnt % 64] <= mem_addr;
      txn_cnt <= txn_cnt + 1;
      if (mem_read_ready) overlap_cnt <= overlap_cnt + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] n;
    logic [31:0] addr;
    int          delay;
    int          exp_txns;
  } vec_t;

  vec_t                  tbl [5];
  logic [IndexWidth-1:0] exp_vec [MaxNodes];

  task automatic start_load(input logic [15:0] n, input logic [31:0] addr, input int delay,
                            output int base);
    @(negedge clock);
    rd_delay         = delay;
    starting_address = addr;
    number_of_nodes  = n;
    enable           = 1'b1;
    base             = txn_cnt;
  endtask

  task automatic wait_ready(input string name, output int cycles);
    cycles = 0;
    while (!ready && cycles < 400) begin
      @(negedge clock);
      cycles++;
    end
    check({name, "_ready"}, 32'(ready), 32'd1);
  endtask

  task automatic update_model(input logic [15:0] n, input logic [31:0] addr);
    int          cnt;
    logic [31:0] a;
    cnt = (n > 16'(MaxNodes)) ? MaxNodes : int'(n);
    for (int i = 0; i < cnt; i++) begin
      a = addr + 32'(4 * i);
      exp_vec[i] = mem[a[7:2]][15:0];
    end
  endtask

  task automatic check_vector(input string name);
    for (int i = 0; i < MaxNodes; i++)
      check($sformatf("%s_entry%0d", name, i), 32'(vector[i]), 32'(exp_vec[i]));
  endtask

  task automatic release_enable(input string name);
    enable = 1'b0;
    @(negedge clock);
    check({name, "_ready_drop"}, 32'(ready), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    int base;
    int cycles;
    int c;
    logic all_zero;

    for (int i = 0; i < 64; i++) mem[i] = {16'hC3A0 ^ 16'(i), 16'(i * 613 + 17)};
    mem[32] = 32'hFFFF_0001;
    mem[33] = 32'hFFFF_0002;
    mem[34] = 32'hFFFF_0004;
    mem[35] = 32'hFFFF_0008;
    for (int i = 0; i < MaxNodes; i++) exp_vec[i] = '0;

    tbl[0] = '{16'd8,  32'h0000_0000, 0, 8};
    tbl[1] = '{16'd3,  32'h0000_0010, 5, 3};
    tbl[2] = '{16'd11, 32'h0000_0000, 1, 8};
    tbl[3] = '{16'd0,  32'h0000_0040, 0, 0};
    tbl[4] = '{16'd2,  32'hFFFF_FFFC, 2, 2};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_mem_read_enable", 32'(mem_read_enable), 32'd0);
    check_vector("rst");

    for (int t = 0; t < 5; t++) begin
      string nm;
      nm = $sformatf("vec%0d", t);
      start_load(tbl[t].n, tbl[t].addr, tbl[t].delay, base);
      wait_ready(nm, cycles);
      if (tbl[t].n == 16'd0) check({nm, "_zero_latency_ok"}, 32'(cycles <= 2), 32'd1);
      update_model(tbl[t].n, tbl[t].addr);
      check_vector(nm);
      check({nm, "_txns"}, 32'(txn_cnt - base), 32'(tbl[t].exp_txns));
      for (int k = 0; k < tbl[t].exp_txns; k++)
        check($sformatf("%s_addr%0d", nm, k), txn_addr[(base + k) % 64],
              tbl[t].addr + 32'(4 * k));
      // Inputs changing after the start must not disturb a finished load.
      starting_address = 32'h0000_0020;
      number_of_nodes  = 16'd5;
      repeat (3) @(negedge clock);
      check({nm, "_hold_ready"}, 32'(ready), 32'd1);
      check({nm, "_hold_txns"}, 32'(txn_cnt - base), 32'(tbl[t].exp_txns));
      check_vector({nm, "_hold"});
      release_enable(nm);
    end

    // Reset while the third request is outstanding, then reload from entry 0.
    start_load(16'd8, 32'h0000_0000, 3, base);
    c = 0;
    while ((txn_cnt - base) < 3 && c < 200) begin
      @(negedge clock);
      c++;
    end
    check("midrst_reached_third", 32'(txn_cnt - base), 32'd3);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_mem_read_enable", 32'(mem_read_enable), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    all_zero = 1'b1;
    for (int i = 0; i < MaxNodes; i++) if (vector[i] != '0) all_zero = 1'b0;
    check("midrst_vector_zero", 32'(all_zero), 32'd1);
    reset  = 1'b0;
    enable = 1'b0;
    @(negedge clock);
    for (int i = 0; i < MaxNodes; i++) exp_vec[i] = '0;
    start_load(16'd8, 32'h0000_0000, 0, base);
    wait_ready("reload", cycles);
    update_model(16'd8, 32'h0000_0000);
    check_vector("reload");
    check("reload_txns", 32'(txn_cnt - base), 32'd8);
    check("reload_first_addr", txn_addr[base % 64], 32'h0000_0000);
    release_enable("reload");

`ifdef VECTOR_READER_CHECKSUM_EN
    start_load(16'd4, 32'h0000_0080, 1, base);
    wait_ready("csum", cycles);
    check("csum_value", 32'(checksum), 32'd15);
    release_enable("csum");
`endif

    check("no_overlapping_reads", 32'(overlap_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
